dbus_axi_bridge: RTL and testbench
==================================

# dbus_axi_bridge

Responder for the core's AXI data-bus port: accepts single-beat read/write requests on the core's simple `axi_*` stall interface and turns each into one AXI4-Lite master transaction toward the peripheral interconnect. It returns read data and a fault flag, and holds `axi_busy` high until the transaction completes. Sits between `core` and the AXI4-Lite crossbar, one instance per hart.

## Interface
- `AXI_ADDR_WIDTH`, default `DEFAULT_AXI_ADDR_WIDTH`: byte address width on both sides.
- `TIMEOUT_CYCLES`, default 256: cycles to wait for each handshake phase before faulting. 0 disables the timeout.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous active-high reset.
- `rd_en`, in, 1: core read request.
- `wr_en`, in, 1: core write request.
- `addr`, in, AXI_ADDR_WIDTH: byte address.
- `wr_data`, in, 32: write data.
- `wr_strobe`, in, 4: byte enables.
- `rd_data`, out, 32: read data.
- `access_fault`, out, 1: transaction failed.
- `busy`, out, 1: stall the core.
- AW channel: `awaddr` out AW; `awprot` out 3; `awvalid` out 1; `awready` in 1.
- W channel: `wdata` out 32; `wstrb` out 4; `wvalid` out 1; `wready` in 1.
- B channel: `bresp` in 2; `bvalid` in 1; `bready` out 1.
- AR channel: `araddr` out AW; `arprot` out 3; `arvalid` out 1; `arready` in 1.
- R channel: `rdata` in 32; `rresp` in 2; `rvalid` in 1; `rready` out 1.

## Operation
- States: IDLE, ADDR, RESP, DONE.
- **IDLE.** When `rd_en|wr_en`:
  - Latch the request: address, data, strobe, and direction. Write wins if both are asserted.
  - Go to ADDR and clear the timeout counter.
- **ADDR, write.** Assert `awvalid` and `wvalid` together.
  - Each deasserts independently after its own handshake.
  - Go to RESP when both handshakes are done, including the case where both happen in the same cycle.
- **ADDR, read.** Assert `arvalid`; go to RESP on `arready`.
- **RESP.** Assert `bready` (write) or `rready` (read).
  - On handshake, capture `rdata` for reads, and set fault = `resp[1]` (SLVERR/DECERR faults, OKAY/EXOKAY do not).
  - Go to DONE.
- **DONE.** One cycle, then IDLE.
  - `rd_en`/`wr_en` seen in DONE belongs to the completing request and is not relaunched.
- **Timeout.**
  - The counter increments every cycle in ADDR or RESP and clears on each phase transition.
  - When it reaches `TIMEOUT_CYCLES`: drop all valids, set fault, go to DONE.
  - `rd_data` is left unchanged on a timeout.
- **Stale responses.** In IDLE, `bready` = `rready` = 1; any response arriving there is consumed and discarded.
- **Fixed fields.**
  - `awprot` = `arprot` = 3'b000.
  - `awaddr`/`araddr` = latched `addr`, unmodified.
  - `wdata`/`wstrb` = latched values.
- **Valid rule.** Valids never deassert before handshake, except on timeout or reset.

## Timing
- **`busy`:**
  - Combinational: `busy = (state==ADDR) | (state==RESP) | (state==IDLE & (rd_en|wr_en))`.
  - Low in DONE.
- **Read, zero-wait slave** (`arready`=1, `rvalid` one cycle after AR):
  - c0: IDLE, request seen, `busy`=1.
  - c1: ADDR, `arvalid`=1, handshake.
  - c2: RESP, R handshake.
  - c3: DONE, `busy`=0, `rd_data` valid.
  - Result: 3 stall cycles.
- **Write, zero-wait slave:** the same 3 stall cycles.
- **Output hold:**
  - `rd_data` is registered and holds until the next successful read.
  - `access_fault` is high only in the DONE cycle.
- **Reset values:**
  - State IDLE.
  - All valids 0.
  - `rd_data`=0, `access_fault`=0, `busy`=0 (with no request).
  - `bready`=`rready`=1.
- **Reset mid-transaction:** immediate return to IDLE with valids dropped. No fault is reported.

## Structure
- Add to package `saratoga`:
  - `axi_resp_t` constants: `AXI_RESP_OKAY`=2'b00, `EXOKAY`=01, `SLVERR`=10, `DECERR`=11.
  - `dbus_bridge_state_t` enum.
- Single module, no sub-modules; the timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits, inline.

## Test plan
- **Read, zero-wait slave.** Read 0x8000_0010, slave returns 0x1234_5678 OKAY → `busy` high exactly 3 cycles; `rd_data`=0x1234_5678 and `access_fault`=0 in DONE.
- **Write, skewed ready.** Write 0xCAFEF00D, strobe 4'b0011; `awready` after 2 cycles, `wready` after 4 → `awvalid` drops after its handshake while `wvalid` holds; `wdata`/`wstrb` correct; RESP entered only after both handshakes.
- **Error response.** Read with `rresp`=SLVERR → `access_fault`=1 for one cycle; `rd_data` updated. Write with `bresp`=DECERR → fault=1.
- **Timeout.** `TIMEOUT_CYCLES`=8, `arready` stuck at 0 → `arvalid` drops after 8 cycles; fault=1; `rd_data` retains its prior value; a late `rvalid` in IDLE is consumed with no effect.
- **Back-to-back and simultaneous requests.** `rd_en` held through DONE, then a new `wr_en` → exactly one AR, then one AW/W. `rd_en`=`wr_en`=1 → only the write is issued.
- **Reset mid-write.** `rst` pulsed while in ADDR → all valids 0 next cycle; state IDLE; `busy`=0; `access_fault`=0.

Source files
------------

// File: rtl/saratoga_pkg.sv
// rtl/saratoga_pkg.sv - shared AXI response codes and data-bus bridge state type
`timescale 1ns/1ps
package saratoga;

    localparam int DEFAULT_AXI_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        DBUS_IDLE,
        DBUS_ADDR,
        DBUS_RESP,
        DBUS_DONE
    } dbus_bridge_state_t;

    function automatic logic axi_resp_is_fault(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/dbus_axi_bridge.sv
// rtl/dbus_axi_bridge.sv - core data-bus stall interface to single-beat AXI4-Lite master
`timescale 1ns/1ps
module dbus_axi_bridge
    import saratoga::*;
#(
    parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    output logic [31:0]               rd_data,
    output logic                      access_fault,
    output logic                      busy,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dbus_bridge_state_t state, state_next;

    logic                      is_write;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic                      aw_done, w_done;
    logic [CNT_W-1:0]          cnt;
    logic [31:0]               rd_data_q;
    logic                      fault_q;

    logic launch, aw_hs, w_hs, ar_hs, resp_hs, addr_phase_done, timeout_hit;

    always_comb begin
        state_next = state;
        launch     = 1'b0;

        awvalid = (state == DBUS_ADDR) && is_write && !aw_done;
        wvalid  = (state == DBUS_ADDR) && is_write && !w_done;
        arvalid = (state == DBUS_ADDR) && !is_write;
        // Stale responses are drained while idle so they cannot leak into the next request.
        bready  = (state == DBUS_IDLE) || ((state == DBUS_RESP) && is_write);
        rready  = (state == DBUS_IDLE) || ((state == DBUS_RESP) && !is_write);
        busy    = (state == DBUS_ADDR) || (state == DBUS_RESP)
                  || ((state == DBUS_IDLE) && (rd_en || wr_en));

        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        ar_hs   = arvalid && arready;
        resp_hs = (state == DBUS_RESP) && (is_write ? bvalid : rvalid);
        addr_phase_done = is_write ? ((aw_done || aw_hs) && (w_done || w_hs)) : ar_hs;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

        case (state)
            DBUS_IDLE: begin
                if (rd_en || wr_en) begin
                    launch     = 1'b1;
                    state_next = DBUS_ADDR;
                end
            end
            DBUS_ADDR: begin
                if (addr_phase_done)  state_next = DBUS_RESP;
                else if (timeout_hit) state_next = DBUS_DONE;
            end
            DBUS_RESP: begin
                if (resp_hs || timeout_hit) state_next = DBUS_DONE;
            end
            default: state_next = DBUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DBUS_IDLE;
            is_write  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cnt       <= '0;
            rd_data_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state   <= state_next;
            fault_q <= 1'b0;

            if (launch) begin
                is_write <= wr_en;
                addr_q   <= addr;
                wdata_q  <= wr_data;
                wstrb_q  <= wr_strobe;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end else if (state == DBUS_ADDR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end

            if (state_next != state)
                cnt <= '0;
            else if ((state == DBUS_ADDR) || (state == DBUS_RESP))
                cnt <= cnt + 1'b1;

            // fault_q only survives the single DONE cycle; any entry to DONE without a response is a timeout.
            if (resp_hs) begin
                fault_q <= axi_resp_is_fault(is_write ? bresp : rresp);
                if (!is_write) rd_data_q <= rdata;
            end else if ((state_next == DBUS_DONE) && (state != DBUS_DONE)) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign awaddr       = addr_q;
    assign araddr       = addr_q;
    assign awprot       = 3'b000;
    assign arprot       = 3'b000;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign rd_data      = rd_data_q;
    assign access_fault = fault_q;

endmodule

// File: tb/tb_dbus_axi_bridge.sv
// tb/tb_dbus_axi_bridge.sv - bench for dbus_axi_bridge against a transaction-level model
`timescale 1ns/1ps
module tb_dbus_axi_bridge;
    import saratoga::*;

    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          rd_en, wr_en;
    logic [AW-1:0] addr;
    logic [31:0]   wr_data, rd_data, wdata, rdata;
    logic [3:0]    wr_strobe, wstrb;
    logic          access_fault, busy;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;

    dbus_axi_bridge #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
        .access_fault(access_fault), .busy(busy),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Slave model: each ready rises after its valid has waited the configured cycles.
    int          ar_dly, aw_dly, w_dly, r_dly, b_dly;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;
    logic        stale_r, allow_drop;
    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic        r_pend, b_pend, aw_seen, w_seen;

    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign rvalid  = (r_pend && (r_cnt >= r_dly)) || stale_r;
    assign bvalid  = b_pend && (b_cnt >= b_dly);
    assign rdata   = cfg_rdata;
    assign rresp   = cfg_resp;
    assign bresp   = cfg_resp;

    wire aw_fin = aw_seen || (awvalid && awready);
    wire w_fin  = w_seen || (wvalid && wready);

    always @(posedge clk) begin
        if (rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
        end else begin
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (arvalid && arready) begin r_pend <= 1'b1; r_cnt <= 0; end
            else if (rvalid && rready) r_pend <= 1'b0;
            else if (r_pend) r_cnt <= r_cnt + 1;
            if (bvalid && bready) b_pend <= 1'b0;
            else if (b_pend) b_cnt <= b_cnt + 1;
            if (aw_fin && w_fin) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                aw_seen <= aw_fin; w_seen <= w_fin;
            end
        end
    end

    // Monitor: handshake counts, captured beats, valid-high cycles, early valid drops.
    int          n_ar = 0, n_aw = 0, n_w = 0, ar_hi = 0, aw_hi = 0, w_hi = 0, viol = 0;
    logic [31:0] last_araddr = 0, last_awaddr = 0, last_wdata = 0;
    logic [3:0]  last_wstrb = 0;
    logic        ar_wait = 0, aw_wait = 0, w_wait = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (arvalid && arready) begin n_ar <= n_ar + 1; last_araddr <= araddr; end
            if (awvalid && awready) begin n_aw <= n_aw + 1; last_awaddr <= awaddr; end
            if (wvalid && wready) begin n_w <= n_w + 1; last_wdata <= wdata; last_wstrb <= wstrb; end
            if (arvalid) ar_hi <= ar_hi + 1;
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid) w_hi <= w_hi + 1;
            if (!allow_drop && ((ar_wait && !arvalid) || (aw_wait && !awvalid) || (w_wait && !wvalid)))
                viol <= viol + 1;
        end
        ar_wait <= arvalid && !arready;
        aw_wait <= awvalid && !awready;
        w_wait  <= wvalid && !wready;
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] m_rd_data = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] resp, input logic [31:0] rdat,
                       input int d_ar, input int d_aw, input int d_w, input int d_r, input int d_b,
                       input bit hold, input string tag);
        int  addr_cyc, exp_busy, busy_n, s_ar, s_aw, s_w, s_arh, s_awh, s_wh;
        bit  to, done, exp_fault;
        ar_dly = d_ar; aw_dly = d_aw; w_dly = d_w; r_dly = d_r; b_dly = d_b;
        cfg_resp = resp; cfg_rdata = rdat;
        addr_cyc = wr ? ((d_aw > d_w ? d_aw : d_w) + 1) : d_ar + 1;
        to = addr_cyc > TO;
        exp_busy = to ? 1 + TO : 1 + addr_cyc + (wr ? d_b : d_r) + 1;
        exp_fault = to || resp == AXI_RESP_SLVERR || resp == AXI_RESP_DECERR;
        if (!wr && !to) m_rd_data = rdat;
        s_ar = n_ar; s_aw = n_aw; s_w = n_w; s_arh = ar_hi; s_awh = aw_hi; s_wh = w_hi;

        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; wr_data = d; wr_strobe = s;
        busy_n = 0; done = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!busy) begin done = 1; break; end
            busy_n++;
            @(negedge clk);
        end
        check({tag, " completes"}, done, 1);
        check({tag, " busy cycles"}, busy_n, exp_busy);
        check({tag, " fault in done"}, access_fault, exp_fault);
        check({tag, " rd_data"}, rd_data, m_rd_data);
        check({tag, " ar count"}, n_ar - s_ar, (!wr && !to) ? 1 : 0);
        check({tag, " aw count"}, n_aw - s_aw, (wr && !to) ? 1 : 0);
        check({tag, " w count"}, n_w - s_w, (wr && !to) ? 1 : 0);
        check({tag, " arvalid cycles"}, ar_hi - s_arh, wr ? 0 : (d_ar + 1 < TO ? d_ar + 1 : TO));
        check({tag, " awvalid cycles"}, aw_hi - s_awh, wr ? (d_aw + 1 < TO ? d_aw + 1 : TO) : 0);
        check({tag, " wvalid cycles"}, w_hi - s_wh, wr ? (d_w + 1 < TO ? d_w + 1 : TO) : 0);
        if (!to && wr) begin
            check({tag, " awaddr"}, last_awaddr, a);
            check({tag, " wdata"}, last_wdata, d);
            check({tag, " wstrb"}, last_wstrb, s);
        end else if (!to) begin
            check({tag, " araddr"}, last_araddr, a);
        end
        if (!hold) begin
            @(negedge clk);
            rd_en = 0; wr_en = 0;
            #1;
            check({tag, " fault after done"}, access_fault, 0);
            check({tag, " idle busy"}, busy, 0);
        end
    endtask

    initial begin
        rst = 1; rd_en = 0; wr_en = 0; addr = 0; wr_data = 0; wr_strobe = 0;
        ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;
        cfg_resp = AXI_RESP_OKAY; cfg_rdata = 0; stale_r = 0; allow_drop = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("reset busy", busy, 0);
        check("reset valids", {awvalid, wvalid, arvalid}, 3'b000);
        check("reset readies", {bready, rready}, 2'b11);
        check("reset rd_data", rd_data, 0);
        check("reset fault", access_fault, 0);
        check("prot fields", {awprot, arprot}, 6'b0);

        txn(0, 1, 32'h8000_0010, 0, 0, AXI_RESP_OKAY, 32'h1234_5678, 0, 0, 0, 0, 0, 0, "read zero-wait");
        txn(1, 0, 32'h8000_0020, 32'hCAFE_F00D, 4'b0011, AXI_RESP_OKAY, 0, 0, 2, 4, 0, 0, 0, "write skewed");
        txn(0, 1, 32'h8000_0030, 0, 0, AXI_RESP_SLVERR, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 0, "read slverr");
        txn(1, 0, 32'h8000_0040, 32'h5555_AAAA, 4'b1111, AXI_RESP_DECERR, 0, 0, 0, 0, 0, 2, 0, "write decerr");
        txn(0, 1, 32'h8000_0050, 0, 0, AXI_RESP_EXOKAY, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0, "read exokay");

        allow_drop = 1;
        txn(0, 1, 32'h8000_0060, 0, 0, AXI_RESP_OKAY, 32'hFFFF_0000, 100, 0, 0, 0, 0, 0, "read timeout");
        allow_drop = 0;
        @(negedge clk);
        stale_r = 1;
        #1;
        check("stale rready", rready, 1);
        check("stale busy", busy, 0);
        @(negedge clk);
        stale_r = 0;
        #1;
        check("stale rd_data", rd_data, m_rd_data);
        check("stale fault", access_fault, 0);

        txn(0, 1, 32'h8000_0070, 0, 0, AXI_RESP_OKAY, 32'h7777_1111, 0, 0, 0, 0, 0, 1, "b2b read");
        txn(1, 0, 32'h8000_0074, 32'h0102_0304, 4'b1000, AXI_RESP_OKAY, 0, 0, 1, 0, 0, 0, 0, "b2b write");
        txn(1, 1, 32'h8000_0080, 32'hA5A5_5A5A, 4'b0101, AXI_RESP_OKAY, 32'h9999_9999, 0, 0, 0, 0, 0, 0, "simultaneous");

        for (int k = 0; k < 16; k++) begin
            bit rw;
            rw = 1'($urandom_range(1, 0));
            txn(rw, rw ? 1'($urandom_range(1, 0)) : 1'b1, $urandom, $urandom, 4'($urandom_range(15, 0)),
                2'($urandom_range(3, 0)), $urandom, $urandom_range(3, 0), $urandom_range(3, 0),
                $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0), 0, "random");
        end

        allow_drop = 1;
        aw_dly = 50; w_dly = 50;
        @(negedge clk);
        wr_en = 1; addr = 32'h8000_0090; wr_data = 32'h1111_2222; wr_strobe = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid-write awvalid", awvalid, 1);
        @(negedge clk);
        rst = 1; wr_en = 0;
        @(negedge clk);
        rst = 0;
        #1;
        check("post-reset valids", {awvalid, wvalid, arvalid}, 3'b000);
        check("post-reset busy", busy, 0);
        check("post-reset fault", access_fault, 0);
        check("post-reset readies", {bready, rready}, 2'b11);
        check("post-reset rd_data", rd_data, 0);
        m_rd_data = 0;
        @(negedge clk);
        allow_drop = 0;

        txn(0, 1, 32'h8000_00A0, 0, 0, AXI_RESP_OKAY, 32'h4242_4242, 0, 0, 0, 0, 0, 0, "read after reset");
        check("valid protocol", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
